// File: rtl/divu_iter.sv
// Iterative radix-2 restoring unsigned divider (MIPS DIVU: q -> LO, r -> HI), one quotient bit per non-stalled cycle.
// Optional macro DIVU_DBZ_FLAG_EN adds a divide-by-zero flag output (dbz).
module divu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             finish,
    input  logic             cpu_stall
`ifdef DIVU_DBZ_FLAG_EN
    ,
    output logic             dbz
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    // rem_q[WIDTH] is always zero after a restoring step; it only acts as a guard bit for the trial subtract.
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial   = {rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
        borrow  = trial[WIDTH+1];
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        if (start) begin
            rem_d   = '0;
            quo_d   = a;
            dvs_d   = b;
            cnt_d   = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!cpu_stall) begin
                        rem_d = borrow ? shifted : trial[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], ~borrow};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = S_DONE;
                            q_d     = quo_d;
                            r_d     = rem_d[WIDTH-1:0];
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

`ifdef DIVU_DBZ_FLAG_EN
    logic dbz_q, dbz_d;

    always_comb begin
        dbz_d = dbz_q;
        if (start) dbz_d = (b == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dbz_q <= 1'b0;
        else        dbz_q <= dbz_d;
    end

    assign dbz = dbz_q;
`endif

    assign q      = q_q;
    assign r      = r_q;
    assign busy   = (state_q == S_RUN);
    assign finish = (state_q == S_DONE);

endmodule

// File: tb/tb_divu_iter.sv
// Scoreboard bench for divu_iter: stimulus pushes model results, a negedge monitor pops on finish.
module tb_divu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cpu_stall;
    logic [W-1:0] a, b, q, r;
    logic         busy, finish;
`ifdef DIVU_DBZ_FLAG_EN
    logic         dbz;
`endif

    always #5 clk = ~clk;

    divu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .q(q), .r(r), .busy(busy), .finish(finish), .cpu_stall(cpu_stall)
`ifdef DIVU_DBZ_FLAG_EN
        , .dbz(dbz)
`endif
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t         sb[$];
    int           total  = 0;
    int           passed = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         fin_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer division; divide by zero yields all-ones quotient and the dividend as remainder.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        if (y == 0) begin
            e.q = '1; e.r = x; e.dbz = 1'b1;
        end else begin
            e.q = x / y; e.r = x % y; e.dbz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && finish === 1'b1) begin
            chk("finish_one_cycle", {63'd0, fin_prev}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_finish", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("q", {32'd0, q}, {32'd0, e.q});
                chk("r", {32'd0, r}, {32'd0, e.r});
`ifdef DIVU_DBZ_FLAG_EN
                chk("dbz", {63'd0, dbz}, {63'd0, e.dbz});
`endif
                last_q = e.q;
                last_r = e.r;
            end
        end
        fin_prev = finish;
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; a = x; b = y;
        sb.push_back(model(x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int stall_at, input int stall_len, input bit rnd, input string tag);
        int cyc = 0;
        int bcyc = 0;
        int stalls = 0;
        chk({tag, "_q_hold"}, {32'd0, q}, {32'd0, last_q});
        chk({tag, "_r_hold"}, {32'd0, r}, {32'd0, last_r});
        while (finish !== 1'b1 && cyc < 300) begin
            if (busy === 1'b1) bcyc++;
            if (rnd) cpu_stall = ($urandom_range(0, 3) == 0);
            else     cpu_stall = (cyc >= stall_at && cyc < stall_at + stall_len);
            if (cpu_stall) stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(32 + stalls));
        chk({tag, "_busy_cycles"}, 64'(bcyc), 64'(32 + stalls));
        cpu_stall = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_finish_drop"}, {63'd0, finish}, 64'd0);
        chk({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
        cpu_stall = 1'b0;
    endtask

    initial begin
        int nf;
        logic [W-1:0] x, y;
        reset = 1'b0; start = 1'b0; cpu_stall = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_finish", {63'd0, finish}, 64'd0);
        chk("rst_q", {32'd0, q}, 64'd0);
        chk("rst_r", {32'd0, r}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        issue(32'd100, 32'd7);
        wait_done(0, 0, 1'b0, "basic");
        chk("basic_q_lit", {32'd0, q}, 64'd14);
        chk("basic_r_lit", {32'd0, r}, 64'd2);

        issue(32'hFFFF_FFFF, 32'd1);
        wait_done(0, 0, 1'b0, "full1");
        issue(32'd5, 32'hFFFF_FFFF);
        wait_done(0, 0, 1'b0, "full2");
        issue(32'h1234_5678, 32'd0);
        wait_done(0, 0, 1'b0, "dbz");
        chk("dbz_q_lit", {32'd0, q}, 64'hFFFF_FFFF);
        chk("dbz_r_lit", {32'd0, r}, 64'h1234_5678);

        issue(32'd1000, 32'd10);
        wait_done(10, 5, 1'b0, "stall");
        chk("stall_q_lit", {32'd0, q}, 64'd100);

        issue(32'd50, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        void'(sb.pop_back());
        issue(32'd81, 32'd9);
        wait_done(0, 0, 1'b0, "restart");
        chk("restart_q_lit", {32'd0, q}, 64'd9);
        chk("restart_r_lit", {32'd0, r}, 64'd0);

        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = '0;
                1:       y = $urandom_range(1, 15);
                2:       y = $urandom;
                3:       y = x >> $urandom_range(0, 31);
                default: y = x;
            endcase
            issue(x, y);
            wait_done(0, 0, 1'b1, "rand");
        end

        issue(32'd77, 32'd5);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_finish", {63'd0, finish}, 64'd0);
        chk("midrst_q", {32'd0, q}, 64'd0);
        chk("midrst_r", {32'd0, r}, 64'd0);
`ifdef DIVU_DBZ_FLAG_EN
        chk("midrst_dbz", {63'd0, dbz}, 64'd0);
`endif
        sb.delete();
        last_q = '0;
        last_r = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        nf = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (finish !== 1'b0) nf++;
        end
        chk("midrst_no_finish", 64'(nf), 64'd0);

        issue(32'd9, 32'd4);
        wait_done(0, 0, 1'b0, "recover");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/divu_iter.md
Name: divu_iter

Overview:
- Iterative 32-bit unsigned divider, the counterpart to the existing unsigned multiply unit.
- Produces quotient and remainder for MIPS DIVU (LO = quotient, HI = remainder).
- Sits beside the multiplier in the EX stage and uses the same start/busy/finish/cpu_stall handshake.
- Uses a radix-2 restoring algorithm: one quotient bit per non-stalled cycle.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low
- start  input  1  one-cycle request; captures a and b
- a  input  WIDTH  dividend
- b  input  WIDTH  divisor
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- busy  output  1  division in progress
- finish  output  1  one-cycle completion pulse
- cpu_stall  input  1  freezes iteration while high

Behaviour:
- Reset (reset=0, asynchronous):
  - busy=0, finish=0, q=0, r=0, counter=0.
  - Internal dividend and divisor shadow registers are cleared.
  - Reset mid-operation aborts the division; no finish pulse follows.
- Working state:
  - rem register is WIDTH+1 bits.
  - quo register is WIDTH bits.
  - dvs register is WIDTH bits.
  - cnt is CNT_W bits.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: finish=1 for exactly one cycle, then return to IDLE.
- Start (any state, including RUN): on the edge where start=1:
  - rem<=0, quo<=a, dvs<=b, cnt<=0, busy<=1, finish<=0.
  - Enter RUN.
  - Start while busy restarts with the new operands.
- RUN, cpu_stall=0: each edge performs one iteration:
  - t = {rem[WIDTH-1:0], quo[WIDTH-1]} - {1'b0, dvs}.
  - If t is non-negative (borrow clear): rem<=t and quo<={quo[WIDTH-2:0],1}.
  - Otherwise: rem<={rem[WIDTH-1:0], quo[WIDTH-1]} and quo<={quo[WIDTH-2:0],0}.
  - cnt<=cnt+1.
- RUN, cpu_stall=1: all state holds; no iteration.
- Completion:
  - On the iteration where cnt==WIDTH-1:
    - busy<=0 and finish<=1.
    - q<=final quotient and r<=final remainder[WIDTH-1:0].
  - finish deasserts on the next edge unless a new start occurs.
- Latency: start at edge N, then iterations at edges N+1..N+WIDTH. With no stall, finish is high in the cycle after edge N+32. Each stalled cycle adds one cycle.
- q and r:
  - Updated only at completion.
  - Hold their previous values through start and RUN.
  - Remain stable until the next completion.
- Divide by zero (b=0):
  - Takes the same 32 iterations, with no special case.
  - Natural result: q=32'hFFFFFFFF, r=a.
- cpu_stall in IDLE or DONE has no effect; the finish pulse is never extended by a stall.
- Arithmetic is unsigned throughout; no overflow is possible.

Optional Feature:
- Macro: DIVU_DBZ_FLAG_EN.
- Defined:
  - Adds output dbz (1 bit, reset 0).
  - dbz is latched from (b==0) at start.
  - dbz is valid alongside finish and holds until the next start.
  - Timing and results are unchanged.
- Undefined:
  - Port dbz is absent.
  - Divide by zero is observable only through the q/r values.

Test Plan:
- Basic divide: a=100, b=7, start for 1 cycle, cpu_stall=0. Expect q=14, r=2, busy high for 32 cycles, finish high 1 cycle, then finish=0.
- Full range: a=32'hFFFFFFFF, b=1, giving q=32'hFFFFFFFF, r=0. Then a=5, b=32'hFFFFFFFF, giving q=0, r=5.
- Divide by zero: a=32'h12345678, b=0, giving q=32'hFFFFFFFF, r=32'h12345678. With DIVU_DBZ_FLAG_EN defined, dbz=1 at finish.
- Stall: a=1000, b=10, cpu_stall=1 for 5 cycles mid-RUN. Expect finish 37 cycles after start, q=100, r=0.
- Restart: a=50, b=3 started, then at cycle 10 of RUN start again with a=81, b=9. Expect a single finish 32 cycles after the second start, q=9, r=0.
- Reset mid-run: reset=0 at cycle 15 of RUN. Expect busy=0, finish=0, q=0, r=0 immediately, and no finish pulse afterwards.
